// File: rtl/fir_seq_pkg.sv
// rtl/fir_seq_pkg.sv - shared widths, state encoding and run-length clamp for the FIR sample sequencer
package fir_seq_pkg;

    localparam int SEQ_DEPTH   = 16;
    localparam int SEQ_AW      = 4;
    localparam int SEQ_XW      = 16;
    localparam int SEQ_YW      = 24;
    localparam int SEQ_TAPS    = 5;
    localparam int SEQ_LATENCY = 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FLUSH = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Requests longer than the buffer run the whole buffer once.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned depth);
        return (len > depth) ? depth : len;
    endfunction

endpackage

// File: rtl/fir_sample_sequencer_if.sv
// rtl/fir_sample_sequencer_if.sv - host/load and FIR-side signal bundle of the sample sequencer
interface fir_sample_sequencer_if #(
    parameter int AW = fir_seq_pkg::SEQ_AW,
    parameter int XW = fir_seq_pkg::SEQ_XW,
    parameter int YW = fir_seq_pkg::SEQ_YW
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [XW-1:0] wr_data;
    logic          start;
    logic [AW:0]   len;
    logic          abort;
    logic          busy;
    logic          done;
    logic [XW-1:0] fir_x_in;
    logic [YW-1:0] fir_y_out;
    logic          y_valid;
    logic [YW-1:0] y_data;
    logic [AW-1:0] y_index;

    modport master (
        output wr_en, wr_addr, wr_data, start, len, abort, fir_y_out,
        input  busy, done, fir_x_in, y_valid, y_data, y_index
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, len, abort, fir_y_out,
        output busy, done, fir_x_in, y_valid, y_data, y_index
    );
endinterface

// File: rtl/fir_sample_mem.sv
// rtl/fir_sample_mem.sv - DEPTH x XW sample register file, one synchronous write, one asynchronous read
module fir_sample_mem #(
    parameter int DEPTH = fir_seq_pkg::SEQ_DEPTH,
    parameter int AW    = fir_seq_pkg::SEQ_AW,
    parameter int XW    = fir_seq_pkg::SEQ_XW
) (
    input  logic          clk,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [XW-1:0] i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [XW-1:0] o_rd_data
);

    logic [XW-1:0] r_mem [DEPTH];

    // Contents survive reset so a host can reload only what changed.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fir_sample_sequencer.sv
// rtl/fir_sample_sequencer.sv - sequences buffered samples through the FIR: flush, stream, tag-align outputs, done
module fir_sample_sequencer
    import fir_seq_pkg::*;
#(
    parameter int DEPTH   = SEQ_DEPTH,
    parameter int AW      = SEQ_AW,
    parameter int XW      = SEQ_XW,
    parameter int YW      = SEQ_YW,
    parameter int TAPS    = SEQ_TAPS,
    parameter int LATENCY = SEQ_LATENCY
) (
    input  logic                   clk,
    input  logic                   reset_n,
    fir_sample_sequencer_if.slave  bus
);

    localparam int LW  = AW + 1;
    localparam int FCW = $clog2(TAPS);

    state_t         r_state;
    state_t         w_next_state;

    logic [LW-1:0]  r_len;
    logic [LW-1:0]  r_rd_ptr;
    logic [FCW-1:0] r_flush_cnt;
    logic           r_busy;
    logic [XW-1:0]  r_fir_x;

    logic [LATENCY-1:0] r_tag_vld;
    logic [AW-1:0]      r_tag_idx [LATENCY];

    logic           r_y_valid;
    logic [YW-1:0]  r_y_data;
    logic [AW-1:0]  r_y_index;

    logic           w_accept;
    logic           w_abort;
    logic           w_load_sample;
    logic           w_flush_last;
    logic           w_last_sample;
    logic           w_tags_empty;
    logic           w_wr_en;
    logic [XW-1:0]  w_rd_data;

    assign w_wr_en = bus.wr_en && !r_busy;

    fir_sample_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .XW    (XW)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (bus.wr_addr),
        .i_wr_data (bus.wr_data),
        .i_rd_addr (r_rd_ptr[AW-1:0]),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_accept      = 1'b0;
        w_load_sample = 1'b0;
        w_abort       = 1'b0;
        w_flush_last  = (r_flush_cnt == FCW'(TAPS - 2));
        w_last_sample = (r_rd_ptr == r_len - 1'b1);
        w_tags_empty  = ~|r_tag_vld;

        case (r_state)
            IDLE: begin
                if (bus.start && (bus.len != '0)) begin
                    w_accept     = 1'b1;
                    w_next_state = FLUSH;
                end
            end
            FLUSH: begin
                if (w_flush_last) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                w_load_sample = 1'b1;
                if (w_last_sample) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (w_tags_empty) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase

        // Abort overrides everything outside IDLE; in IDLE a coincident start wins.
        if (bus.abort && (r_state != IDLE)) begin
            w_abort       = 1'b1;
            w_load_sample = 1'b0;
            w_next_state  = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_len       <= '0;
            r_rd_ptr    <= '0;
            r_flush_cnt <= '0;
            r_busy      <= 1'b0;
            r_fir_x     <= '0;
            r_tag_vld   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_tag_idx[i] <= '0;
            end
            r_y_valid   <= 1'b0;
            r_y_data    <= '0;
            r_y_index   <= '0;
        end else begin
            r_busy <= (w_next_state == FLUSH) || (w_next_state == RUN) || (w_next_state == DRAIN);

            if (w_accept) begin
                r_len       <= LW'(clamp_len(32'(bus.len), DEPTH));
                r_rd_ptr    <= '0;
                r_flush_cnt <= '0;
            end else if (r_state == FLUSH) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end

            if (w_load_sample) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            // Zeros go out in every non-RUN state so the delay line is clean at both ends of a run.
            r_fir_x <= w_load_sample ? w_rd_data : '0;

            if (w_abort) begin
                r_tag_vld <= '0;
                r_y_valid <= 1'b0;
            end else begin
                r_tag_vld[0] <= w_load_sample;
                r_tag_idx[0] <= r_rd_ptr[AW-1:0];
                for (int i = 1; i < LATENCY; i++) begin
                    r_tag_vld[i] <= r_tag_vld[i-1];
                    r_tag_idx[i] <= r_tag_idx[i-1];
                end
                r_y_valid <= r_tag_vld[LATENCY-1];
                if (r_tag_vld[LATENCY-1]) begin
                    r_y_data  <= bus.fir_y_out;
                    r_y_index <= r_tag_idx[LATENCY-1];
                end
            end
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = (r_state == DONE);
    assign bus.fir_x_in = r_fir_x;
    assign bus.y_valid  = r_y_valid;
    assign bus.y_data   = r_y_data;
    assign bus.y_index  = r_y_index;

endmodule

// File: tb/tb_fir_sample_sequencer.sv
// tb/tb_fir_sample_sequencer.sv - directed self-checking bench for fir_sample_sequencer with a sign-extending FIR stub
module tb_fir_sample_sequencer;

    logic clk;
    logic reset_n;

    fir_sample_sequencer_if bus ();

    fir_sample_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // FIR stub: the registered fir_x_in is the single stage of latency, output is x sign-extended.
    assign bus.fir_y_out = {{8{bus.fir_x_in[15]}}, bus.fir_x_in};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_mem [16];

    int          cyc = 0;
    logic [3:0]  yq_idx [$];
    logic [23:0] yq_data [$];
    int          done_cnt;
    int          done_cyc;
    int          overlap;
    int          busy_first;
    int          busy_last;
    int          busy_cnt;
    int          last_yv_cyc;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always begin
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        if (bus.y_valid) begin
            yq_idx.push_back(bus.y_index);
            yq_data.push_back(bus.y_data);
            last_yv_cyc = cyc;
            if (bus.done) overlap++;
        end
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.busy) begin
            if (busy_first < 0) busy_first = cyc;
            busy_last = cyc;
            busy_cnt++;
        end
    end

    task automatic write_mem(input logic [3:0] addr, input logic [15:0] data);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        @(negedge clk);
        bus.wr_en   = 1'b0;
        exp_mem[addr] = data;
    endtask

    task automatic start_run(input logic [4:0] l, output int c0);
        @(negedge clk);
        yq_idx.delete();
        yq_data.delete();
        done_cnt    = 0;
        done_cyc    = -1;
        overlap     = 0;
        busy_first  = -1;
        busy_last   = -1;
        busy_cnt    = 0;
        last_yv_cyc = -1;
        bus.start   = 1'b1;
        bus.len     = l;
        c0          = cyc + 1;
        @(negedge clk);
        bus.start   = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_done_cnt"}, done_cnt, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_run(input string tag, input int c0, input int n_out, input int done_off);
        logic [23:0] exp_y;
        check_eq({tag, "_ycount"}, yq_data.size(), n_out);
        for (int k = 0; k < n_out; k++) begin
            exp_y = {{8{exp_mem[k][15]}}, exp_mem[k]};
            if (k < yq_data.size())
                check_eq($sformatf("%s_y%0d", tag, k), {yq_idx[k], yq_data[k]}, {k[3:0], exp_y});
        end
        check_eq({tag, "_done_cyc"}, done_cyc, c0 + done_off);
        check_eq({tag, "_done_cnt_final"}, done_cnt, 1);
        check_eq({tag, "_overlap"}, overlap, 0);
        check_eq({tag, "_busy_first"}, busy_first, c0);
        check_eq({tag, "_busy_last"}, busy_last, c0 + done_off - 1);
        check_eq({tag, "_busy_cnt"}, busy_cnt, done_off);
    endtask

    initial begin
        int c0;
        reset_n     = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.start   = 1'b0;
        bus.len     = '0;
        bus.abort   = 1'b0;
        for (int i = 0; i < 16; i++) exp_mem[i] = 16'h0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy",     bus.busy,     1'b0);
        check_eq("rst_done",     bus.done,     1'b0);
        check_eq("rst_fir_x",    bus.fir_x_in, 16'h0);
        check_eq("rst_y_valid",  bus.y_valid,  1'b0);
        check_eq("rst_y_data",   bus.y_data,   24'h0);
        check_eq("rst_y_index",  bus.y_index,  4'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Full run: 0x0001..0x0010, len=16.
        for (int i = 0; i < 16; i++) write_mem(i[3:0], 16'(i + 1));
        start_run(5'd16, c0);
        check_eq("t1_busy_e0", bus.busy, 1'b1);
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            check_eq($sformatf("t1_flush_e%0d", n), bus.fir_x_in, 16'h0);
        end
        @(negedge clk);
        check_eq("t1_first_x_e5", bus.fir_x_in, 16'h0001);
        wait_done("t1", 40);
        check_run("t1", c0, 16, 22);

        // len=1 with a negative sample.
        write_mem(4'd0, 16'h8000);
        start_run(5'd1, c0);
        wait_done("t2", 20);
        check_run("t2", c0, 1, 7);
        check_eq("t2_y_data_sext", yq_data.size() > 0 ? yq_data[0] : 24'h0, 24'hFF8000);

        // len=0 is ignored.
        start_run(5'd0, c0);
        repeat (10) @(negedge clk);
        check_eq("t3a_busy_never", busy_first, -1);
        check_eq("t3a_done_cnt",   done_cnt, 0);
        check_eq("t3a_ycount",     yq_data.size(), 0);

        // len=20 clamps to 16.
        start_run(5'd20, c0);
        wait_done("t3b", 40);
        check_run("t3b", c0, 16, 22);

        // Abort raised after E8, sampled at E9.
        start_run(5'd16, c0);
        repeat (8) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check_eq("t4_busy_after_e9",  bus.busy,     1'b0);
        check_eq("t4_fir_x_after_e9", bus.fir_x_in, 16'h0);
        check_eq("t4_yv_after_e9",    bus.y_valid,  1'b0);
        repeat (25) @(negedge clk);
        check_eq("t4_no_done",   done_cnt, 0);
        check_eq("t4_ycount",    yq_data.size(), 3);
        check_eq("t4_last_yv",   last_yv_cyc, c0 + 8);
        start_run(5'd4, c0);
        wait_done("t4b", 30);
        check_run("t4b", c0, 4, 10);

        // Write and start while busy are both dropped.
        start_run(5'd16, c0);
        repeat (10) @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'd3;
        bus.wr_data = 16'hDEAD;
        @(negedge clk);
        bus.wr_en   = 1'b0;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.len     = 5'd2;
        @(negedge clk);
        bus.start   = 1'b0;
        wait_done("t5", 40);
        check_run("t5", c0, 16, 22);
        start_run(5'd4, c0);
        wait_done("t5b", 30);
        check_run("t5b", c0, 4, 10);

        // Asynchronous reset in the middle of RUN.
        start_run(5'd16, c0);
        repeat (8) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_eq("t6_busy",    bus.busy,     1'b0);
        check_eq("t6_fir_x",   bus.fir_x_in, 16'h0);
        check_eq("t6_y_valid", bus.y_valid,  1'b0);
        check_eq("t6_y_data",  bus.y_data,   24'h0);
        check_eq("t6_y_index", bus.y_index,  4'h0);
        check_eq("t6_done",    bus.done,     1'b0);
        #9 reset_n = 1'b1;
        @(negedge clk);
        check_eq("t6_no_done", done_cnt, 0);
        start_run(5'd16, c0);
        wait_done("t6b", 40);
        check_run("t6b", c0, 16, 22);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_sample_sequencer.md
Name: fir_sample_sequencer

Overview:
- Controller that owns the sample stream into the 5-tap high-pass FIR datapath (firtop: x_in[15:0] in, y_out[23:0] out).
- Holds a 16-entry sample buffer, loaded through a write port.
- On start: flushes the FIR delay line with zeros, then streams len samples into the FIR, captures each aligned output with an index tag, and signals done.
- Sits between the host/load logic and firtop; replaces free-running memory-driven stimulus with a sequenced, handshaked run.

Parameters:
- DEPTH, 16, sample buffer entries (power of 2).
- AW, 4, buffer address width, log2(DEPTH).
- XW, 16, FIR input sample width.
- YW, 24, FIR output width.
- TAPS, 5, FIR tap count; flush length is TAPS-1 zeros.
- LATENCY, 1, edges from loading sample k into fir_x_in to the edge at which fir_y_out holds y[k].

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- wr_en  in  1  buffer write strobe.
- wr_addr  in  AW  buffer write address.
- wr_data  in  XW  buffer write data.
- start  in  1  run request, single-cycle pulse.
- len  in  AW+1  samples per run, 1..DEPTH.
- abort  in  1  synchronous run cancel.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at run completion.
- fir_x_in  out  XW  sample to FIR x_in, registered.
- fir_y_out  in  YW  FIR y_out.
- y_valid  out  1  y_data/y_index valid, one cycle per sample.
- y_data  out  YW  captured FIR output.
- y_index  out  AW  buffer index of the sample that produced y_data.

Behaviour:
- Reset (async, any state): state IDLE; fir_x_in=0, busy=0, done=0, y_valid=0, y_data=0, y_index=0; read pointer, counters and tag pipeline cleared. Buffer contents are not reset.
- States: IDLE -> FLUSH -> RUN -> DRAIN -> DONE -> IDLE.

IDLE:
- start=1 with len!=0 is accepted at edge E0: len latched, busy=1 after E0, state FLUSH.
- len=0: start ignored.
- len>DEPTH: clamped to DEPTH.

FLUSH:
- fir_x_in loaded with 0 at edges E1..E(TAPS-1).
- Then RUN.

RUN:
- Sample k = buffer[k] loaded into fir_x_in at edge E(TAPS+k), for k=0..len-1.
- After the last load, state DRAIN.

Tag pipeline:
- LATENCY-deep shift register carries {valid, index} alongside each loaded sample.
- At edge E(TAPS+k+LATENCY): y_data<=fir_y_out, y_index<=k, y_valid=1 for the following cycle.
- Exactly len y_valid pulses per run, consecutive, indexes ascending from 0.

DRAIN:
- fir_x_in loaded with 0 each edge until the tag pipeline is empty.

DONE:
- done=1 for one cycle, starting after edge E(TAPS+len+LATENCY).
- busy drops with the same edge.
- Return to IDLE.
- done and the last y_valid never coincide.

Buffer:
- 1 write port, asynchronous read.
- wr_en honoured only when busy=0.
- wr_en while busy is dropped silently.
- wr_en and start on the same edge in IDLE: the write lands, and the first read happens TAPS edges later.

Other boundaries:
- start while busy: ignored.
- abort=1 in any non-IDLE state: next edge returns to IDLE with busy=0, fir_x_in=0, tag pipeline flushed, y_valid=0, and no done pulse.
- abort in IDLE: no effect.
- abort and start on the same cycle in IDLE: start wins.
- Reset mid-run: immediate return to reset values; the next start after release runs normally.

Width rules:
- y_data is passed through unmodified, with no truncation or sign manipulation.
- Pointer increments within AW bits; no wrap occurs because len is at most DEPTH.

Decomposition:
- Package fir_seq_pkg holds:
  - the state enum {IDLE, FLUSH, RUN, DRAIN, DONE};
  - default widths XW/YW/AW and TAPS;
  - the len-clamp function.
- Sub-module fir_sample_mem: DEPTH x XW register file, one synchronous write port, one asynchronous read port.
- FSM, counters and tag pipeline stay in the top.

Test Plan:
- Bench uses a behavioural FIR stub: y = sign-extended x, delayed LATENCY=1.
- Full run:
  - Stimulus: load buffer 0x0001..0x0010, start with len=16 at E0.
  - Required: fir_x_in=0 at E1..E4, then 0x0001 at E5.
  - Required: 16 y_valid pulses, y_data 0x000001..0x000010, y_index 0..15.
  - Required: done is a single cycle after E22; busy is high from after E0 through E22.
- len=1 with buffer[0]=0x8000:
  - Required: one y_valid with y_data=0xFF8000, y_index=0.
  - Required: done after E7.
- len=0 and len=20:
  - Required: len=0 leaves busy and done at 0 and starts nothing.
  - Required: len=20 produces exactly 16 outputs.
- Abort:
  - Stimulus: abort at E8 of a len=16 run.
  - Required: busy=0 and fir_x_in=0 after E9, no done, no y_valid after E9.
  - Required: a following start completes normally.
- Write-while-busy and start-while-busy:
  - Stimulus: wr_en to addr 3 with 0xDEAD mid-run, then start mid-run.
  - Required: buffer[3] is unchanged in the next run's y_data; the run length is unaffected.
- Reset mid-run:
  - Stimulus: reset_n low for 10 ns during RUN.
  - Required: all outputs go to 0 asynchronously; the next run completes correctly.
